// File: rtl/dsp_sub_arbiter.sv
// Round-robin arbiter feeding a shared two-lane subtract unit: up to two requesters
// are granted per cycle, and each requester's lane result is held in its own response slot.
module dsp_sub_arbiter_slot #(
  parameter int width = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             grant,
  input  logic             resp_ready,
  input  logic [width-1:0] y_in,
  output logic             resp_valid,
  output logic [width-1:0] resp_y
);
  // A new grant wins over a same-cycle accept, so the slot refills without a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_y     <= '0;
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_y     <= y_in;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end
endmodule

module dsp_sub_arbiter #(
  parameter int width = 24,
  parameter int nreq  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [nreq-1:0]       req_valid,
  output logic [nreq-1:0]       req_ready,
  input  logic [nreq*width-1:0] req_a,
  input  logic [nreq*width-1:0] req_b,
  output logic [width-1:0]      dsp_a0,
  output logic [width-1:0]      dsp_b0,
  output logic [width-1:0]      dsp_a1,
  output logic [width-1:0]      dsp_b1,
  input  logic [width-1:0]      dsp_y0,
  input  logic [width-1:0]      dsp_y1,
  output logic [nreq-1:0]       resp_valid,
  input  logic [nreq-1:0]       resp_ready,
  output logic [nreq*width-1:0] resp_y,
  output logic [15:0]           issue_count
);
  typedef struct packed {
    logic [width-1:0] a;
    logic [width-1:0] b;
  } lane_op_t;

  logic [nreq-1:0][width-1:0] a_arr, b_arr, y_arr;
  logic [nreq-1:0]            eligible, gnt0, gnt1;
  logic [1:0]                 rr, idx0, idx1, cand, last;
  logic                       hit0, hit1;
  logic [1:0]                 ngrant;
  logic [16:0]                cnt_sum;
  lane_op_t                   op0, op1;

  assign a_arr    = req_a;
  assign b_arr    = req_b;
  assign resp_y   = y_arr;
  assign eligible = req_valid & (~resp_valid | resp_ready) & {nreq{reset}};

  // Walk the requesters in rotation from rr; first hit takes lane 0, second lane 1.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    idx0 = '0;
    idx1 = '0;
    cand = '0;
    for (int k = 0; k < nreq; k++) begin
      cand = rr + 2'(k);
      if (eligible[cand]) begin
        if (!hit0) begin
          hit0 = 1'b1;
          idx0 = cand;
        end else if (!hit1) begin
          hit1 = 1'b1;
          idx1 = cand;
        end
      end
    end
  end

  always_comb begin
    gnt0 = '0;
    gnt1 = '0;
    op0  = '0;
    op1  = '0;
    if (hit0) begin
      gnt0[idx0] = 1'b1;
      op0.a      = a_arr[idx0];
      op0.b      = b_arr[idx0];
    end
    if (hit1) begin
      gnt1[idx1] = 1'b1;
      op1.a      = a_arr[idx1];
      op1.b      = b_arr[idx1];
    end
  end

  assign req_ready = gnt0 | gnt1;
  assign dsp_a0    = op0.a;
  assign dsp_b0    = op0.b;
  assign dsp_a1    = op1.a;
  assign dsp_b1    = op1.b;

  assign last    = hit1 ? idx1 : idx0;
  assign ngrant  = {1'b0, hit0} + {1'b0, hit1};
  assign cnt_sum = {1'b0, issue_count} + 17'(ngrant);

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr          <= '0;
      issue_count <= '0;
    end else begin
      if (hit0) rr <= last + 2'd1;
      issue_count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  for (genvar i = 0; i < nreq; i++) begin : g_slot
    dsp_sub_arbiter_slot #(.width(width)) u_slot (
      .clock      (clock),
      .reset      (reset),
      .grant      (req_ready[i]),
      .resp_ready (resp_ready[i]),
      .y_in       (gnt1[i] ? dsp_y1 : dsp_y0),
      .resp_valid (resp_valid[i]),
      .resp_y     (y_arr[i])
    );
  end
endmodule

// File: tb/tb_dsp_sub_arbiter.sv
// Randomized and directed bench for dsp_sub_arbiter against a queue-based grant model.
module tb_dsp_sub_arbiter;
  localparam int W = 24;

  logic             clock, reset;
  logic [3:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [4*W-1:0]   req_a, req_b, resp_y;
  logic [W-1:0]     dsp_a0, dsp_b0, dsp_a1, dsp_b1, dsp_y0, dsp_y1;
  logic [15:0]      issue_count;

  int checks = 0;
  int passed = 0;

  // model state
  logic [3:0]        m_vld;
  logic [3:0][W-1:0] m_y;
  int                m_rr, m_cnt;
  int                g[$];
  logic [3:0]        exp_ready;
  logic [4*W-1:0]    exp_lanes;

  dsp_sub_arbiter #(.width(W), .nreq(4)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0),
    .dsp_a1(dsp_a1), .dsp_b1(dsp_b1), .dsp_y0(dsp_y0), .dsp_y1(dsp_y1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_y(resp_y),
    .issue_count(issue_count)
  );

  // external subtract unit
  assign dsp_y0 = dsp_a0 - dsp_b0;
  assign dsp_y1 = dsp_a1 - dsp_b1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [W-1:0] lane_a(int j);
    return (j < g.size()) ? req_a[g[j]*W +: W] : '0;
  endfunction

  function automatic logic [W-1:0] lane_b(int j);
    return (j < g.size()) ? req_b[g[j]*W +: W] : '0;
  endfunction

  // Rotate from the pointer and take the first two requesters that may issue.
  function automatic void plan();
    g.delete();
    exp_ready = '0;
    for (int k = 0; k < 4; k++) begin
      int i = (m_rr + k) % 4;
      if (reset && req_valid[i] && (!m_vld[i] || resp_ready[i]) && g.size() < 2)
        g.push_back(i);
    end
    foreach (g[j]) exp_ready[g[j]] = 1'b1;
    exp_lanes = {lane_a(0), lane_b(0), lane_a(1), lane_b(1)};
  endfunction

  function automatic void commit();
    if (!reset) begin
      m_vld = '0; m_y = '0; m_rr = 0; m_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (exp_ready[i]) begin
          m_vld[i] = 1'b1;
          m_y[i]   = req_a[i*W +: W] - req_b[i*W +: W];
        end else if (resp_ready[i]) m_vld[i] = 1'b0;
      end
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % 4;
      m_cnt = (m_cnt + g.size() > 65535) ? 65535 : m_cnt + g.size();
    end
  endfunction

  task automatic settle();
    #1;
    plan();
  endtask

  task automatic clk_commit();
    @(posedge clock);
    commit();
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[i*W +: W] = W'($urandom);
      req_b[i*W +: W] = W'($urandom);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 4'hF; resp_ready = 4'h0; rand_ops();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++; if (req_ready !== 4'h0) $display("FAIL reset_ready act=%h exp=0", req_ready); else passed++;
      checks++; if ({dsp_a0, dsp_b0, dsp_a1, dsp_b1} !== '0) $display("FAIL reset_lanes act=%h exp=0", {dsp_a0, dsp_b0, dsp_a1, dsp_b1}); else passed++;
      clk_commit();
      checks++; if (resp_valid !== 4'h0) $display("FAIL reset_vld act=%h exp=0", resp_valid); else passed++;
      checks++; if (resp_y !== '0) $display("FAIL reset_y act=%h exp=0", resp_y); else passed++;
      checks++; if (issue_count !== 16'h0) $display("FAIL reset_cnt act=%h exp=0", issue_count); else passed++;
    end
    reset = 1'b1; req_valid = 4'h0;
    settle(); clk_commit();
  endtask

  task automatic test_single();
    req_valid = 4'b0001; resp_ready = 4'h0;
    req_a[0 +: W] = 24'd10; req_b[0 +: W] = 24'd3;
    settle();
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready act=%h exp=1", req_ready); else passed++;
    checks++; if (dsp_a0 !== 24'd10 || dsp_b0 !== 24'd3 || dsp_a1 !== '0 || dsp_b1 !== '0)
      $display("FAIL single_lanes act=%h exp=%h", {dsp_a0, dsp_b0, dsp_a1, dsp_b1}, exp_lanes); else passed++;
    clk_commit();
    checks++; if (resp_valid !== 4'b0001) $display("FAIL single_vld act=%h exp=1", resp_valid); else passed++;
    checks++; if (resp_y[0 +: W] !== 24'd7) $display("FAIL single_y act=%0d exp=7", resp_y[0 +: W]); else passed++;
    checks++; if (issue_count !== 16'd1) $display("FAIL single_cnt act=%0d exp=1", issue_count); else passed++;
    // drain, then all valid: pointer now at 1 so grants go to 1 and 2
    req_valid = 4'h0; resp_ready = 4'hF;
    settle(); clk_commit();
    checks++; if (resp_valid !== 4'h0) $display("FAIL single_drain act=%h exp=0", resp_valid); else passed++;
    req_valid = 4'hF;
    settle();
    checks++; if (req_ready !== 4'b0110) $display("FAIL single_rr act=%h exp=6", req_ready); else passed++;
    clk_commit();
  endtask

  task automatic test_all_valid();
    reset = 1'b0; settle(); clk_commit(); reset = 1'b1;
    req_valid = 4'hF; resp_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      rand_ops();
      settle();
      checks++; if (req_ready !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) $display("FAIL all_ready c=%0d act=%h", c, req_ready); else passed++;
      checks++; if ({dsp_a0, dsp_b0, dsp_a1, dsp_b1} !== exp_lanes) $display("FAIL all_lanes act=%h exp=%h", {dsp_a0, dsp_b0, dsp_a1, dsp_b1}, exp_lanes); else passed++;
      clk_commit();
      checks++; if (issue_count !== 16'(2*(c+1))) $display("FAIL all_cnt act=%0d exp=%0d", issue_count, 2*(c+1)); else passed++;
      checks++; if (resp_y !== m_y) $display("FAIL all_y act=%h exp=%h", resp_y, m_y); else passed++;
    end
  endtask

  task automatic test_wrap();
    req_valid = 4'b1010; resp_ready = 4'hF;
    req_a[1*W +: W] = 24'd0; req_b[1*W +: W] = 24'd1;
    req_a[3*W +: W] = 24'd5; req_b[3*W +: W] = 24'd9;
    settle(); clk_commit();
    checks++; if (resp_y[1*W +: W] !== 24'hFFFFFF) $display("FAIL wrap_0m1 act=%h exp=ffffff", resp_y[1*W +: W]); else passed++;
    checks++; if (resp_y[3*W +: 8] !== 8'hFC) $display("FAIL wrap_5m9 act=%h exp=fc", resp_y[3*W +: 8]); else passed++;
    checks++; if (resp_valid !== m_vld) $display("FAIL wrap_vld act=%h exp=%h", resp_valid, m_vld); else passed++;
  endtask

  task automatic test_backpressure();
    req_valid = 4'h0; resp_ready = 4'hF;
    settle(); clk_commit();
    req_valid = 4'b0100; resp_ready = 4'h0;
    req_a[2*W +: W] = 24'd100; req_b[2*W +: W] = 24'd1;
    settle();
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_first act=%h exp=4", req_ready); else passed++;
    clk_commit();
    req_a[2*W +: W] = 24'd50; req_b[2*W +: W] = 24'd8;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (req_ready[2] !== 1'b0) $display("FAIL bp_stall act=%b exp=0", req_ready[2]); else passed++;
      clk_commit();
      checks++; if (resp_valid[2] !== 1'b1 || resp_y[2*W +: W] !== 24'd99) $display("FAIL bp_hold act=%0d exp=99", resp_y[2*W +: W]); else passed++;
    end
    resp_ready = 4'b0100;
    settle();
    checks++; if (req_ready !== 4'b0100) $display("FAIL bp_regrant act=%h exp=4", req_ready); else passed++;
    clk_commit();
    checks++; if (resp_valid[2] !== 1'b1 || resp_y[2*W +: W] !== 24'd42) $display("FAIL bp_new act=%0d exp=42", resp_y[2*W +: W]); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 39) != 0);
      req_valid = 4'($urandom); resp_ready = 4'($urandom); rand_ops();
      settle();
      checks++; if (req_ready !== exp_ready) $display("FAIL rnd_ready c=%0d act=%h exp=%h", c, req_ready, exp_ready); else passed++;
      checks++; if ({dsp_a0, dsp_b0, dsp_a1, dsp_b1} !== exp_lanes) $display("FAIL rnd_lanes c=%0d act=%h exp=%h", c, {dsp_a0, dsp_b0, dsp_a1, dsp_b1}, exp_lanes); else passed++;
      clk_commit();
      checks++; if (resp_valid !== m_vld) $display("FAIL rnd_vld c=%0d act=%h exp=%h", c, resp_valid, m_vld); else passed++;
      checks++; if (resp_y !== m_y) $display("FAIL rnd_y c=%0d act=%h exp=%h", c, resp_y, m_y); else passed++;
      checks++; if (issue_count !== 16'(m_cnt)) $display("FAIL rnd_cnt c=%0d act=%0d exp=%0d", c, issue_count, m_cnt); else passed++;
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'hF; resp_ready = 4'h0; rand_ops();
    settle(); clk_commit();
    settle(); clk_commit();
    reset = 1'b0;
    settle();
    checks++; if (req_ready !== 4'h0) $display("FAIL mid_ready act=%h exp=0", req_ready); else passed++;
    clk_commit();
    checks++; if (resp_valid !== 4'h0) $display("FAIL mid_vld act=%h exp=0", resp_valid); else passed++;
    checks++; if (issue_count !== 16'h0) $display("FAIL mid_cnt act=%0d exp=0", issue_count); else passed++;
    reset = 1'b1;
    settle();
    checks++; if (req_ready !== 4'b0011) $display("FAIL mid_first act=%h exp=3", req_ready); else passed++;
    clk_commit();
    checks++; if (resp_valid !== 4'b0011 || resp_y !== m_y) $display("FAIL mid_resp act=%h exp=%h", resp_y, m_y); else passed++;
  endtask

  task automatic test_saturate();
    reset = 1'b0; settle(); clk_commit(); reset = 1'b1;
    req_valid = 4'hF; resp_ready = 4'hF;
    for (int c = 0; c < 32767; c++) begin
      settle(); clk_commit();
    end
    checks++; if (issue_count !== 16'hFFFE) $display("FAIL sat_pre act=%h exp=fffe", issue_count); else passed++;
    for (int c = 0; c < 3; c++) begin
      settle(); clk_commit();
      checks++; if (issue_count !== 16'hFFFF) $display("FAIL sat_hold c=%0d act=%h exp=ffff", c, issue_count); else passed++;
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    m_vld = '0; m_y = '0; m_rr = 0; m_cnt = 0;
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dsp_sub_arbiter.md
DSP_SUB_ARBITER -- requirements
Module: dsp_sub_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 24, giving the operand and result width, legal range 1..24.
REQ-002 The block SHALL have parameter nreq, fixed at 4, giving the number of requesters.
REQ-003 Port clock SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-low reset.
REQ-005 Port req_valid SHALL be an input, 4 bits: per-requester request valid.
REQ-006 Port req_ready SHALL be an output, 4 bits: per-requester grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-007 Port req_a SHALL be an input, 4*width bits: minuend for requester i at [i*width +: width].
REQ-008 Port req_b SHALL be an input, 4*width bits: subtrahend for requester i, same packing.
REQ-009 Port dsp_a0/dsp_b0/dsp_a1/dsp_b1 SHALL be outputs, width bits each: lane 0 and lane 1 operands to the shared two-lane subtract unit.
REQ-010 Port dsp_y0/dsp_y1 SHALL be inputs, width bits each: combinational lane results, y = a - b.
REQ-011 Port resp_valid SHALL be an output, 4 bits: per-requester result valid.
REQ-012 Port resp_ready SHALL be an input, 4 bits: per-requester result accept.
REQ-013 Port resp_y SHALL be an output, 4*width bits: registered result for requester i, same packing.
REQ-014 Port issue_count SHALL be an output, 16 bits: count of accepted requests, saturating.

Function
REQ-015 Eligibility SHALL be eligible[i] = req_valid[i] & (~resp_valid[i] | resp_ready[i]) & reset.
REQ-016 Each cycle the block SHALL grant at most two eligible requesters by round-robin search starting at pointer rr (2 bits): the first found takes lane 0, the second takes lane 1.
REQ-017 req_ready SHALL be combinational: req_ready[i]=1 only for granted requesters; req_ready SHALL never depend on req_valid of the same requester except through eligibility.
REQ-018 Lane operands SHALL carry the granted requester's req_a/req_b; an unused lane SHALL drive zeros.
REQ-019 On a grant, resp_y[i] SHALL capture the lane result and resp_valid[i] SHALL be set at the next rising edge (latency 1 cycle from acceptance).
REQ-020 A result SHALL hold stable while resp_valid[i] & ~resp_ready[i]; resp_valid[i] SHALL clear on resp_ready[i] unless a new grant to i occurs the same cycle, in which case it stays 1 with the new result.
REQ-021 The arithmetic SHALL be (a - b) mod 2^width, with no overflow flag.
REQ-022 rr SHALL advance to (index of last granted requester + 1) mod 4 when any grant occurs, else hold; the wrap from 3 to 0 SHALL be covered.
REQ-023 issue_count SHALL increase by the number of grants (0, 1 or 2) per cycle and saturate at 16'hFFFF.
REQ-024 With zero eligible requesters, there SHALL be no grant, lanes SHALL be zero, and rr and issue_count SHALL hold.

Reset
REQ-025 While reset=0 at a rising edge: resp_valid=0, resp_y=0, rr=0, issue_count=0.
REQ-026 While reset=0, req_ready SHALL be 0 and lane operands SHALL be zero.
REQ-027 Reset asserted mid-transfer SHALL discard pending results; no resp_valid SHALL appear in the cycle after reset deasserts.

Verification
REQ-028 Single request: req_valid=4'b0001, a0=10, b0=3 -> req_ready=0001 on lane 0; next cycle resp_valid[0]=1, resp_y[0]=7; rr=1; issue_count=1.
REQ-029 All four valid every cycle, resp_ready=4'hF -> grants {0,1}, then {2,3}, then {0,1}; two issues per cycle; issue_count increments by 2.
REQ-030 Wrap-around: width=24, a=0, b=1 -> resp_y=24'hFFFFFF; width=8, a=5, b=9 -> resp_y=8'hFC.
REQ-031 Backpressure: resp_valid[2]=1, resp_ready[2]=0, req_valid[2]=1 -> req_ready[2]=0 and resp_y[2] stable; then resp_ready[2]=1 -> grant to 2 the same cycle, with resp_valid[2] staying 1 carrying the new value.
REQ-032 Reset mid-operation: all requesters active, reset=0 for 1 cycle -> resp_valid=0, issue_count=0, rr=0; first grant after release goes to requester 0.
